// File: rtl/imem_loader.sv
// Frames a UART byte stream into 32-bit words and writes them into the kernel or user program region.
// Optional checksum trailer byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int unsigned MAX_WORDS   = 64,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [31:0] USER_BASE   = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {IDLE, REGION, CNT_HI, CNT_LO, DATA, CHECK} state_t;
`else
  typedef enum logic [2:0] {IDLE, REGION, CNT_HI, CNT_LO, DATA} state_t;
`endif

  state_t      state_q, state_d;
  logic        region_q, region_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        wr_en_d, busy_d, done_d, err_d;
  logic [31:0] wr_addr_d, wr_data_d;
  logic [15:0] cnt_full;
  logic [31:0] base;
  logic        timeout;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign cnt_full = {count_q[15:8], rx_data};
  assign base     = region_q ? USER_BASE : '0;
  // A byte arriving in the expiry cycle always wins over the abort.
  assign timeout  = (TIMEOUT_CYC != 0) && (state_q != IDLE) && !rx_valid &&
                    (tcnt_q + 32'd1 >= TIMEOUT_CYC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      region_q <= 1'b0;
      count_q  <= '0;
      idx_q    <= '0;
      bidx_q   <= '0;
      word_q   <= '0;
      tcnt_q   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      tcnt_q   <= tcnt_d;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    count_d   = count_q;
    idx_d     = idx_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    busy_d    = busy;
    done_d    = done;
    err_d     = err;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif
    if (state_q == IDLE || rx_valid) tcnt_d = '0;
    else                             tcnt_d = tcnt_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == 8'hA5) begin
          state_d = REGION;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          bidx_d  = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      REGION: begin
        if (rx_valid) begin
          region_d = rx_data[0];
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_valid) begin
          count_d = {rx_data, 8'h00};
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (rx_valid) begin
          count_d = cnt_full;
          if (cnt_full == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = CHECK;
`else
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else if (32'(cnt_full) > MAX_WORDS) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            bidx_d  = '0;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          bidx_d = bidx_q + 2'd1;
          word_d = {word_q[15:0], rx_data};
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bidx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base + {14'd0, idx_q, 2'b00};
            wr_data_d = {word_q, rx_data};
            idx_d     = idx_q + 16'd1;
            if (idx_q == count_q - 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_d = CHECK;
`else
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CHECK: begin
        if (rx_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (rx_data == csum_q) done_d = 1'b1;
          else                   err_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are sent and popped on wr_en.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] payload[$];

  imem_loader #(.MAX_WORDS(64), .TIMEOUT_CYC(100), .USER_BASE(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Write monitor: every wr_en must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) chkb("unexpected_wr", wr_en, 1'b0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", wr_addr, e[63:32]);
        chk("wr_data", wr_data, e[31:0]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is captured.
  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input logic [7:0] region, input logic bad);
    logic [7:0]  xs;
    logic [7:0]  b;
    logic [31:0] base;
    logic [15:0] n;
    n    = 16'(payload.size());
    base = region[0] ? 32'h0040_0000 : 32'h0;
    xs   = '0;
    drive(8'hA5);
    chkb("busy_sync", busy, 1'b1);
    chkb("done_clr", done, 1'b0);
    chkb("err_clr", err, 1'b0);
    drive(region);
    drive(n[15:8]);
    drive(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      sb.push_back({base + 32'(i) * 32'd4, payload[i]});
      for (int j = 0; j < 4; j++) begin
        b  = payload[i][31 - 8 * j -: 8];
        xs = xs ^ b;
        drive(b);
        if (i == int'(n) - 1 && j == 2) chkb("busy_mid", busy, 1'b1);
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    chkb("done_pre_csum", done, 1'b0);
    chkb("busy_pre_csum", busy, 1'b1);
    drive(bad ? (xs ^ 8'h07) : xs);
`endif
    chkb("done_end", done, !bad);
    chkb("err_end", err, bad);
    chkb("busy_end", busy, 1'b0);
    payload.delete();
    idle(2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_err", err, 1'b0);
    reset = 1'b0;
    idle(2);

    // Single kernel word
    payload.push_back(32'h0800_0003);
    frame(8'h00, 1'b0);

    // Two user words
    payload.push_back(32'h0000_E820);
    payload.push_back(32'h3C1D_4000);
    frame(8'h01, 1'b0);

    // Count over MAX_WORDS, then a count=0 frame clears err
    drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h41);
    chkb("over_err", err, 1'b1);
    chkb("over_busy", busy, 1'b0);
    chkb("over_done", done, 1'b0);
    drive(8'hA5);
    chkb("resync_err", err, 1'b0);
    chkb("resync_busy", busy, 1'b1);
    drive(8'h00); drive(8'h00); drive(8'h00);
`ifdef IMEM_LOADER_CSUM_EN
    chkb("zero_busy_pre_csum", busy, 1'b1);
    drive(8'h00);
`endif
    chkb("zero_done", done, 1'b1);
    chkb("zero_busy", busy, 1'b0);
    idle(2);

    // Sync byte value inside data
    payload.push_back(32'hA5A5_A5A5);
    frame(8'h00, 1'b0);

    // Exactly MAX_WORDS words
    for (int i = 0; i < 64; i++) payload.push_back($urandom);
    frame(8'h00, 1'b0);

    // Timeout after one of two words
    drive(8'hA5); drive(8'h01); drive(8'h00); drive(8'h02);
    sb.push_back({32'h0040_0000, 32'hDEAD_BEEF});
    drive(8'hDE); drive(8'hAD); drive(8'hBE); drive(8'hEF);
    idle(99);
    chkb("to_pre_err", err, 1'b0);
    chkb("to_pre_busy", busy, 1'b1);
    idle(1);
    chkb("to_err", err, 1'b1);
    chkb("to_busy", busy, 1'b0);
    chkb("to_done", done, 1'b0);
    idle(2);

    // Byte arriving on the expiry cycle keeps the frame alive
    drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h01);
    sb.push_back({32'h0, 32'h1122_3344});
    drive(8'h11); drive(8'h22);
    idle(99);
    drive(8'h33);
    chkb("edge_err", err, 1'b0);
    chkb("edge_busy", busy, 1'b1);
    drive(8'h44);
`ifdef IMEM_LOADER_CSUM_EN
    drive(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
    chkb("edge_done", done, 1'b1);
    idle(2);

    // Reset mid-DATA after a nonzero user write
    payload.push_back(32'h0BAD_CAFE);
    frame(8'h01, 1'b0);
    drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h01);
    drive(8'h77); drive(8'h66);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_addr", wr_addr, 32'h0);
    chk("mid_rst_data", wr_data, 32'h0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_done", done, 1'b0);
    reset = 1'b0;
    idle(2);
    payload.push_back(32'hCAFE_F00D);
    frame(8'h00, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
    // Bad checksum: word still written, err set
    payload.push_back(32'h0800_0003);
    frame(8'h00, 1'b1);
`endif

    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
